// File: rtl/reg_bank_rr_arbiter.sv
// Round-robin write arbiter in front of a shared register bank with combinational read.
// Optional REG_ARB_LOCK_EN lets an accepted requester holding req_lock keep top priority.

module reg_bank_rr_arbiter_regs #(
    parameter int               WIDTH = 8,
    parameter int               AW    = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             real_clk,
    input  logic             real_rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] ce;

    always_comb begin
        ce = '0;
        for (int a = 0; a < DEPTH; a++) begin
            ce[a] = wr_en && (wr_addr == AW'(a));
        end
    end

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= INIT;
            end
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (ce[a]) begin
                    mem[a] <= wr_data;
                end
            end
        end
    end

    // No write-to-read bypass: readers see the new value only after the edge.
    assign rd_data = mem[rd_addr];
endmodule

module reg_bank_rr_arbiter #(
    parameter int                NREQ  = 4,
    parameter int                WIDTH = 8,
    parameter int                AW    = 2,
    parameter logic [WIDTH-1:0]  INIT  = '0,
    localparam int               PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  real_clk,
    input  logic                  real_rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_lock,
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic [PW-1:0]         last_grant,
    output logic                  wr_strobe
);
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [PW-1:0]    gnt_idx;
    logic [PW:0]      cand;
    logic             accept;
    logic [NREQ-1:0]  grant;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
        return (v == PW'(NREQ - 1)) ? '0 : v + 1'b1;
    endfunction

    // Search ptr, ptr+1, ... modulo NREQ; the first valid requester wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        accept  = 1'b0;
        cand    = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!accept && req_valid[cand[PW-1:0]]) begin
                accept  = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
        if (real_rst) begin
            accept = 1'b0;
        end
        if (accept) begin
            grant[gnt_idx] = 1'b1;
            wr_addr        = req_addr[gnt_idx*AW +: AW];
            wr_data        = req_data[gnt_idx*WIDTH +: WIDTH];
        end
    end

    assign req_ready = grant;

`ifdef REG_ARB_LOCK_EN
    logic lock_act;
    logic lock_nxt;

    // While locked, ptr already points at the holder, so a cycle with no
    // accept means the holder went idle and priority moves past it.
    always_comb begin
        ptr_nxt  = ptr;
        lock_nxt = lock_act;
        if (accept) begin
            lock_nxt = req_lock[gnt_idx];
            ptr_nxt  = req_lock[gnt_idx] ? gnt_idx : inc_wrap(gnt_idx);
        end else if (lock_act) begin
            lock_nxt = 1'b0;
            ptr_nxt  = inc_wrap(ptr);
        end
    end

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            lock_act <= 1'b0;
        end else begin
            lock_act <= lock_nxt;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;

    always_comb begin
        ptr_nxt = ptr;
        if (accept) begin
            ptr_nxt = inc_wrap(gnt_idx);
        end
    end
`endif

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            ptr        <= '0;
            last_grant <= '0;
            wr_strobe  <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            wr_strobe <= accept;
            if (accept) begin
                last_grant <= gnt_idx;
            end
        end
    end

    reg_bank_rr_arbiter_regs #(
        .WIDTH (WIDTH),
        .AW    (AW),
        .INIT  (INIT)
    ) u_regs (
        .real_clk (real_clk),
        .real_rst (real_rst),
        .wr_en    (accept),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );
endmodule

// File: doc/reg_bank_rr_arbiter.md
Name: reg_bank_rr_arbiter

Overview:
Round-robin write arbiter sharing one bank of clock-enabled, async-reset registers between NREQ requesters. Each requester presents a valid/ready write request (address + data). The arbiter grants at most one write per cycle and drives the write enable of the addressed register. A combinational read port and grant status expose bank contents and scheduling state to downstream datapath logic.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data width of each register
AW, 2, address width; bank depth DEPTH = 2**AW
INIT, 0, reset value of every bank register (WIDTH bits)

Ports:
real_clk  input  1  clock, rising edge
real_rst  input  1  reset, asynchronous, active-high
req_valid  input  NREQ  per-requester write request
req_ready  output  NREQ  per-requester grant/accept (one-hot or zero)
req_addr  input  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_data  input  NREQ*WIDTH  packed data, requester i at [i*WIDTH +: WIDTH]
req_lock  input  NREQ  per-requester lock request (used only with REG_ARB_LOCK_EN)
rd_addr  input  AW  read address
rd_data  output  WIDTH  bank[rd_addr], combinational
last_grant  output  clog2(NREQ)  index of last accepted requester, registered
wr_strobe  output  1  registered pulse: a write was accepted in the previous cycle

Behaviour:
- Reset (real_rst=1, asynchronous): all bank entries <= INIT; ptr <= 0; last_grant <= 0; wr_strobe <= 0; req_ready forced to 0 while real_rst is high.
- Priority pointer ptr (clog2(NREQ) bits): search order is ptr, ptr+1, ..., wrapping modulo NREQ.
- Grant is combinational in the same cycle: req_ready[i]=1 only for the first valid requester in search order. No valid requesters -> req_ready=0.
- Accept = req_valid[i] & req_ready[i].
  - On the next rising edge: bank[req_addr[i]] <= req_data[i] (that entry's CE asserted, all others hold).
  - last_grant <= i; wr_strobe <= 1.
  - ptr <= (i+1) mod NREQ; wrap from NREQ-1 to 0 is required.
- No accept: ptr, last_grant and bank hold; wr_strobe <= 0.
- Fairness: a continuously valid requester is granted within NREQ cycles.
- Read: rd_data reflects the old value during the write cycle and the new value from the cycle after the edge. No bypass.
- Multiple requesters targeting the same address in successive cycles: the later accept wins. Each accept is a full overwrite.
- Reset asserted mid-cycle: the in-flight write is lost; the bank shows INIT immediately.
- Deassertion of real_rst is synchronous to real_clk by the integrator; the arbiter resumes with ptr=0.
- Latency: request to bank update is 1 edge; request to wr_strobe is 1 edge.

Optional Feature:
Macro: REG_ARB_LOCK_EN.
- Defined:
  - If the requester accepted in cycle t had req_lock[i]=1, ptr <= i instead of i+1, so it keeps top priority.
  - It is granted again whenever valid, supporting atomic multi-register updates.
  - Lock is released, and ptr advances to i+1, on the first accept with req_lock[i]=0, or on a cycle where req_valid[i]=0.
- Undefined: req_lock is ignored (port kept, unused) and ptr always advances to i+1.

Test Plan:
1. Reset check: assert real_rst with INIT=8'h5A -> every rd_addr reads 8'h5A; req_ready=0; last_grant=0; wr_strobe=0.
2. Single write: req0 valid, addr=2, data=8'h3C -> req_ready=4'b0001 same cycle; next cycle rd_data@2=8'h3C, last_grant=0, wr_strobe=1, ptr=1.
3. Round-robin: all four requesters valid for 8 cycles with distinct data -> grant order 0,1,2,3,0,1,2,3; each wins exactly twice.
4. Wrap and skip: ptr=3, only req1 and req3 valid -> req3 granted, then ptr=0 -> req1 granted next; last_grant sequence 3,1.
5. Async reset mid-write: req2 writes 8'hFF to addr 1 and real_rst pulses between edges -> addr1 reads INIT; ptr=0; wr_strobe=0.
6. REG_ARB_LOCK_EN: req1 valid with lock=1 for 3 cycles while req2 valid -> req1 granted 3 consecutive cycles. Lock drops -> req1 granted once more, then req2.
